jmulticycle_adder: RTL and testbench

Parametrised multi-cycle ripple-carry adder/subtractor for the arithmetic datapath. It processes one CHUNK-bit slice per clock, LSB slice first, using a single shared ripple-carry slice adder, so a WIDTH-bit result costs WIDTH/CHUNK cycles instead of one long combinational carry chain. Operands enter and results leave through valid/ready handshakes. Operating modes are add and subtract, with carry-out and signed-overflow flags.

---
 rtl/jmulticycle_adder_pkg.sv | 25 ++
 rtl/jmulticycle_adder_chunk_rca.sv | 39 +++
 rtl/jmulticycle_adder.sv | 148 ++++++++++++++
 tb/tb_jmulticycle_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jmulticycle_adder_pkg.sv
// -----------------------------------------------------------------------------
// jmulticycle_adder_pkg
// Shared definitions for the multi-cycle ripple-carry adder/subtractor:
//   - state_t        : controller state encoding (IDLE, RUN, DONE)
//   - calc_nchunk()  : number of CHUNK-bit slices in a WIDTH-bit operand
//   - calc_idx_w()   : width of the slice index register (never below 1)
// -----------------------------------------------------------------------------
package jmulticycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/jmulticycle_adder_chunk_rca.sv
// -----------------------------------------------------------------------------
// jchunk_rca
// Combinational CHUNK-bit ripple-carry slice adder, shared by every cycle of a
// multi-cycle operation.
//   a, b      : slice operands (b already inverted by the caller for subtract)
//   cin       : carry into bit 0
//   s         : slice sum
//   cout      : carry out of the slice MSB
//   c_msb_in  : carry into the slice MSB; XOR with cout gives signed overflow
//               when this slice holds the operand MSB
// -----------------------------------------------------------------------------
module jchunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // c[i] is the carry into bit i; c[CHUNK] is the slice carry-out.
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/jmulticycle_adder.sv
// -----------------------------------------------------------------------------
// jmulticycle_adder
// Multi-cycle ripple-carry adder/subtractor. One CHUNK-bit slice is added per
// clock, LSB slice first, through a single shared jchunk_rca instance, so a
// WIDTH-bit result takes WIDTH/CHUNK cycles.
//
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, carryin, sub)
//   a, b                 : WIDTH-bit operands
//   carryin              : carry-in for add, borrow-in for subtract
//   sub                  : 0 = a+b+carryin, 1 = a-b-carryin
//   out_valid / out_ready: result handshake (sum, carryout, overflow)
//   sum                  : WIDTH-bit result
//   carryout             : raw carry out of the MSB (1 = no borrow on subtract)
//   overflow             : two's-complement signed overflow
//   state_dbg            : current controller state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 exactly in IDLE and out_valid exactly in DONE; both are
// decoded from the state register only, so neither depends combinationally on
// the partner's valid/ready. Once a result is presented it stays stable until
// it transfers; the next operands can transfer no earlier than the following
// edge because the block first has to return to IDLE.
// -----------------------------------------------------------------------------
module jmulticycle_adder
  import jmulticycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output state_t           state_dbg
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NCHUNK - 1);

  // Illegal slicing is rejected while the design is elaborated.
  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("jmulticycle_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;      // b, or ~b when subtracting
  logic             carry;    // carry into the slice currently being added
  logic [IDX_W-1:0] k;        // index of the slice currently being added
  logic [WIDTH-1:0] sum_q;
  logic             carryout_q;
  logic             overflow_q;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             slice_c_msb_in;

  // Select slice k of the latched operands for the shared slice adder.
  always_comb begin
    slice_a = opa[int'(k) * CHUNK +: CHUNK];
    slice_b = opb[int'(k) * CHUNK +: CHUNK];
  end

  jchunk_rca #(
    .CHUNK (CHUNK)
  ) u_rca (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb_in)
  );

  // Controller and datapath registers. Subtraction is a + ~b + ~borrow_in,
  // which is why the initial carry is carryin ^ sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      opa        <= '0;
      opb        <= '0;
      carry      <= 1'b0;
      k          <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= carryin ^ sub;
            k     <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          sum_q[int'(k) * CHUNK +: CHUNK] <= slice_s;
          carry <= slice_cout;
          if (k == K_LAST) begin
            // The last slice holds the operand MSB, so its internal carries
            // give the final carry-out and the signed-overflow flag.
            carryout_q <= slice_cout;
            overflow_q <= slice_c_msb_in ^ slice_cout;
            state      <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_jmulticycle_adder.sv
// -----------------------------------------------------------------------------
// tb_jmulticycle_adder
// Directed and random checks of jmulticycle_adder in three configurations:
//   id 0 : WIDTH=16, CHUNK=4  (4 slices)
//   id 1 : WIDTH=16, CHUNK=16 (single slice)
//   id 2 : WIDTH=16, CHUNK=1  (16 slices)
// Inputs change on the falling clock edge, outputs are read there too.
// -----------------------------------------------------------------------------
module tb_jmulticycle_adder;
  import jmulticycle_adder_pkg::*;

  localparam int W = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [W-1:0] a_in      [3];
  logic [W-1:0] b_in      [3];
  logic         cin_in    [3];
  logic         sub_in    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] sum_o     [3];
  logic         cout_o    [3];
  logic         ovf_o     [3];
  state_t       st_o      [3];

  jmulticycle_adder #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_in[0]), .b(b_in[0]), .carryin(cin_in[0]), .sub(sub_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum_o[0]),
    .carryout(cout_o[0]), .overflow(ovf_o[0]), .state_dbg(st_o[0])
  );

  jmulticycle_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_in[1]), .b(b_in[1]), .carryin(cin_in[1]), .sub(sub_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum_o[1]),
    .carryout(cout_o[1]), .overflow(ovf_o[1]), .state_dbg(st_o[1])
  );

  jmulticycle_adder #(.WIDTH(W), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_in[2]), .b(b_in[2]), .carryin(cin_in[2]), .sub(sub_in[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum_o[2]),
    .carryout(cout_o[2]), .overflow(ovf_o[2]), .state_dbg(st_o[2])
  );

  // ---------------------------------------------------------------- scoreboard
  // Entry layout: {carryout, overflow, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: integer arithmetic on the operands, independent of slicing.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic sb);
    logic [W:0] full;
    logic       co;
    int         sx;
    int         sy;
    int         t;
    sx = int'(signed'(x));
    sy = int'(signed'(y));
    if (!sb) begin
      full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      co   = full[W];
      t    = sx + sy + int'(ci);
    end else begin
      full = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
      co   = ~full[W];           // negative difference means a borrow
      t    = sx - sy - int'(ci);
    end
    return {co, ((t > 32767) || (t < -32768)), full[W-1:0]};
  endfunction

  // ---------------------------------------------------------------- drivers
  // All driver tasks start and end on a falling clock edge.
  task automatic drive_op(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb);
    check($sformatf("in_ready_before_accept_d%0d", id), 32'(in_ready[id]), 32'd1);
    a_in[id]     = x;
    b_in[id]     = y;
    cin_in[id]   = ci;
    sub_in[id]   = sb;
    in_valid[id] = 1'b1;
    @(negedge clk);
    in_valid[id] = 1'b0;
  endtask

  // Waits for out_valid (bounded), checks latency and the result fields.
  task automatic wait_result(input int id, input int lat);
    int cyc;
    cyc = 0;
    check($sformatf("out_valid_low_after_accept_d%0d", id), 32'(out_valid[id]), 32'd0);
    while (!out_valid[id] && (cyc < lat + 8)) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency_d%0d", id), 32'(cyc), 32'(lat));
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      last_exp = exp_q.pop_front();
      check($sformatf("sum_d%0d", id), 32'(sum_o[id]), 32'(last_exp[W-1:0]));
      check($sformatf("carryout_d%0d", id), 32'(cout_o[id]), 32'(last_exp[W+1]));
      check($sformatf("overflow_d%0d", id), 32'(ovf_o[id]), 32'(last_exp[W]));
    end
  endtask

  task automatic ack(input int id);
    out_ready[id] = 1'b1;
    @(negedge clk);
    out_ready[id] = 1'b0;
    check($sformatf("in_ready_after_transfer_d%0d", id), 32'(in_ready[id]), 32'd1);
    check($sformatf("out_valid_after_transfer_d%0d", id), 32'(out_valid[id]), 32'd0);
  endtask

  task automatic run_op(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb, input int lat);
    exp_q.push_back(ref_model(x, y, ci, sb));
    drive_op(id, x, y, ci, sb);
    wait_result(id, lat);
    ack(id);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      a_in[i]      = '0;
      b_in[i]      = '0;
      cin_in[i]    = 1'b0;
      sub_in[i]    = 1'b0;
      out_ready[i] = 1'b0;
    end

    // Reset state while rst_n is held low.
    #3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_in_ready_d%0d", i), 32'(in_ready[i]), 32'd1);
      check($sformatf("reset_out_valid_d%0d", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("reset_sum_d%0d", i), 32'(sum_o[i]), 32'd0);
      check($sformatf("reset_carryout_d%0d", i), 32'(cout_o[i]), 32'd0);
      check($sformatf("reset_overflow_d%0d", i), 32'(ovf_o[i]), 32'd0);
      check($sformatf("reset_state_d%0d", i), 32'(st_o[i]), 32'(IDLE));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add and carry/overflow corners, 4-bit slices.
    run_op(0, 16'd3,     16'd2,     1'b1, 1'b0, 4);
    run_op(0, 16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 4);
    run_op(0, 16'h7FFF,  16'd1,     1'b0, 1'b0, 4);
    // Subtract.
    run_op(0, 16'd5,     16'd7,     1'b0, 1'b1, 4);
    run_op(0, 16'h8000,  16'd1,     1'b0, 1'b1, 4);
    run_op(0, 16'd10,    16'd3,     1'b1, 1'b1, 4);
    run_op(0, 16'h8000,  16'h0000,  1'b1, 1'b1, 4);

    // Backpressure: result must stay frozen while inputs wiggle.
    exp_q.push_back(ref_model(16'h1234, 16'h0F0F, 1'b0, 1'b0));
    drive_op(0, 16'h1234, 16'h0F0F, 1'b0, 1'b0);
    wait_result(0, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      a_in[0]     = 16'($urandom_range(0, 65535));
      b_in[0]     = 16'($urandom_range(0, 65535));
      sub_in[0]   = ~i[0];
      @(negedge clk);
      check($sformatf("bp_sum_c%0d", i), 32'(sum_o[0]), 32'(last_exp[W-1:0]));
      check($sformatf("bp_flags_c%0d", i), 32'({cout_o[0], ovf_o[0]}), 32'(last_exp[W+1:W]));
      check($sformatf("bp_in_ready_c%0d", i), 32'(in_ready[0]), 32'd0);
      check($sformatf("bp_out_valid_c%0d", i), 32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    ack(0);
    // Next operation presented immediately: accepted on the following edge.
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 4);

    // Reset two cycles into RUN discards the operation.
    drive_op(0, 16'hABCD, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid[0]), 32'd0);
    check("midreset_sum", 32'(sum_o[0]), 32'd0);
    check("midreset_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 16'hABCD, 16'h1111, 1'b0, 1'b0, 4);

    // Random vectors on the 4-bit-slice instance.
    for (int i = 0; i < 10; i++) begin
      run_op(0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4);
    end

    // Single-slice instance: one-cycle latency.
    run_op(1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1);
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1);

    // Bit-serial instance: sixteen-cycle latency, corners plus random vectors.
    run_op(2, 16'h7FFF, 16'd1,    1'b0, 1'b0, 16);
    run_op(2, 16'd5,    16'd7,    1'b0, 1'b1, 16);
    for (int i = 0; i < 100; i++) begin
      run_op(2, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
